// File: rtl/lsu_bus_bridge_if.sv
// lsu_bus_bridge_if: single-beat memory bus between the LSU bridge (master) and memory (slave).
interface lsu_bus_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_be, input bus_rdata, bus_ack);
    modport slave (input bus_req, bus_we, bus_addr, bus_wdata, bus_be, output bus_rdata, bus_ack);
endinterface

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: RV32I load/store to single-beat bus bridge with ack timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module lsu_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              err,
    lsu_bus_bridge_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ld_data;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d, err_q, err_d;
    logic        access, illegal, misalign, expired;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    assign access  = mem_read | mem_write;
    assign illegal = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (mem_write && funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign expired = cnt_q == 8'(TIMEOUT_CYCLES - 1);
    assign bus.bus_req   = state_q == REQ;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_be    = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                           f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign bus.bus_wdata = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                           f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign ld_byte = bus.bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = bus.bus_rdata[{addr_q[1], 4'b0000} +: 16];
    // funct3[2] selects zero extension (lbu/lhu)
    assign ld_data = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & ld_byte[7]}}, ld_byte} :
                     f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & ld_half[15]}}, ld_half} : bus.bus_rdata;
    assign rdata = rdata_q;
    assign err   = err_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = access;
                if (access) begin
                    addr_d  = addr;
                    f3_d    = funct3;
                    wdata_d = wdata;
                    we_d    = mem_write;
                    cnt_d   = 8'd0;
                    state_d = illegal || misalign ? DONE : REQ;
                    err_d   = illegal || misalign;
                    rdata_d = illegal || misalign ? 32'd0 : rdata_q;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    rdata_d = we_q ? rdata_q : ld_data;
                    state_d = DONE;
                end else if (expired) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // while reset is held the FSM is treated as already idle
        if (reset) stall = access;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: directed and randomized accesses checked against a byte-lane reference model.
module tb_lsu_bus_bridge;
    localparam int TO = 16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
    logic        stall, err;
    logic [31:0] model_rdata = 32'd0;
    int          checks = 0, failures = 0;
    lsu_bus_bridge_if bus ();
    lsu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err), .bus(bus.master)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction
    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a % 4) / nbytes(f3)) * nbytes(f3);
    endfunction
    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << nbytes(f3)) - 1) << lane_off(f3, a));
    endfunction
    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nbytes(f3)) +: 8];
        return r;
    endfunction
    function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        int n = nbytes(f3);
        logic [31:0] mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        logic [31:0] v = (word >> (8 * lane_off(f3, a))) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction
    function automatic bit trapped(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bit mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = legal && (a % nbytes(f3)) != 0;
`endif
        return !legal || mis;
    endfunction
    // ack_at: REQ cycle index (0 = first) on which memory acks; >= TO means never
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w, input int ack_at, input logic [31:0] word);
        bit bad = trapped(wr, f3, a);
        bit acked = 1'b0;
        bit exp_err = 1'b1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = w;
        bus.bus_ack = 1'b0; bus.bus_rdata = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'd1);
        chk("idle_req", 32'(bus.bus_req), 32'd0);
        @(posedge clk); #1;
        if (!bad) begin
            for (int k = 0; k < TO && !acked; k++) begin
                chk("req_req", 32'(bus.bus_req), 32'd1);
                chk("req_stall", 32'(stall), 32'd1);
                if (k == 0) begin
                    chk("req_addr", bus.bus_addr, a & ~32'h3);
                    chk("req_be", 32'(bus.bus_be), 32'(exp_be(f3, a)));
                    chk("req_we", 32'(bus.bus_we), 32'(wr));
                    if (wr) chk("req_wdata", bus.bus_wdata, exp_wd(f3, w));
                end
                acked = k == ack_at;
                bus.bus_ack = acked; bus.bus_rdata = word;
                @(posedge clk); #1;
                bus.bus_ack = 1'b0; bus.bus_rdata = $urandom;
            end
            exp_err = !acked;
            if (!acked) model_rdata = 32'd0;
            else if (!wr) model_rdata = exp_ld(f3, a, word);
        end else begin
            model_rdata = 32'd0;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(bus.bus_req), 32'd0);
        chk("done_err", 32'(err), 32'(exp_err));
        chk("done_rdata", rdata, model_rdata);
        @(posedge clk); #1;
        chk("back_idle_err", 32'(err), 32'd0);
        chk("back_idle_req", 32'(bus.bus_req), 32'd0);
    endtask
    initial begin
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus.bus_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall_idle", 32'(stall), 32'd0);
        mem_read = 1'b1; #1;
        chk("rst_stall_rule", 32'(stall), 32'd1);
        mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 32'h0);
        access(1, 0, 3'b000, 32'h203, 32'h0, 0, 32'h80112233);
        chk("lb_value", rdata, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h203, 32'h0, 1, 32'h80112233);
        chk("lbu_value", rdata, 32'h00000080);
        access(1, 0, 3'b101, 32'h202, 32'h0, 2, 32'h80112233);
        chk("lhu_value", rdata, 32'h00008011);
        access(0, 1, 3'b000, 32'h301, 32'h000000A5, 0, 32'h0);
        access(1, 0, 3'b010, 32'h40, 32'h0, 99, 32'h12345678);
        chk("timeout_rdata", rdata, 32'h0);
        access(1, 0, 3'b010, 32'h44, 32'h0, TO - 1, 32'hCAFEF00D);
        access(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h55AA55AA);
        access(1, 0, 3'b011, 32'h10, 32'h0, 0, 32'h1);
        access(0, 1, 3'b100, 32'h10, 32'h77, 0, 32'h1);
        access(1, 1, 3'b001, 32'h3FE, 32'h0000BEEF, 0, 32'h1);
        // reset in the third REQ cycle, then a stray ack
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500; bus.bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_req_active", 32'(bus.bus_req), 32'd1);
        reset = 1'b1; #1;
        chk("mid_rst_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; mem_read = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFFFFFF;
        model_rdata = 32'd0;
        chk("mid_rst_req", 32'(bus.bus_req), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        chk("late_ack_req", 32'(bus.bus_req), 32'd0);
        chk("late_ack_err", 32'(err), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        chk("late_ack_rdata", rdata, 32'd0);
        for (int i = 0; i < 80; i++) begin
            int dir = $urandom_range(0, 2);
            int sel = $urandom_range(0, 9);
            int ack_at = sel == 0 ? 99 : sel == 1 ? TO - 1 : $urandom_range(0, 3);
            access(dir != 1, dir != 0, 3'($urandom_range(0, 7)), $urandom, $urandom, ack_at, $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
